mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the byte-addressed unified memory (524288 bytes, combinational read, posedge write). It shares the single memory port between the instruction-fetch unit and the load/store unit. It drives the memory's `pc`, `rw_addr`, `rw_val` and `mem_write_enable` from registered state, returns fetched instructions and load data through per-requester response pulses, and flags out-of-range accesses without touching memory.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single port of the byte-addressed unified memory between the
// instruction-fetch unit and the load/store unit. Each transaction takes
// three cycles: grant (IDLE), memory access (ACCESS), response pulse (RESP).
// Data normally wins arbitration. Fetch wins when it is the only requester,
// or once it has lost STARVE_MAX times in a row. Out-of-range accesses run
// the full sequence but never write memory, and their data reads back as 0.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   if_req/if_addr    fetch request and 64-bit byte address
//   if_gnt            fetch accepted on this edge (combinational, IDLE only)
//   if_rvalid/if_rdata/if_err
//                     one-cycle fetch response, instruction word, range error
//   d_req/d_we/d_addr/d_wdata
//                     data request: 8-byte store (d_we=1) or 8-byte load
//   d_gnt             data request accepted on this edge (combinational, IDLE)
//   d_rvalid/d_rdata/d_err
//                     one-cycle data response, load data (0 for stores and
//                     errors), range error
//   mem_pc, mem_rw_addr, mem_rw_val, mem_write_enable
//                     registered drive of the memory port
//   mem_instruction, mem_r_out
//                     combinational read data returned by the memory
//   busy              high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MEM_BYTES  = 524288,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic [63:0] mem_pc,
    output logic [31:0] mem_rw_addr,
    output logic [63:0] mem_rw_val,
    output logic        mem_write_enable,
    input  logic [31:0] mem_instruction,
    input  logic [63:0] mem_r_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Highest legal start address for a 4-byte fetch and an 8-byte data access.
    localparam logic [63:0] IF_LIMIT   = 64'(MEM_BYTES - 4);
    localparam logic [31:0] D_LIMIT    = 32'(MEM_BYTES - 8);
    localparam logic [2:0]  STARVE_TOP = 3'(STARVE_MAX);

    state_t      state;
    state_t      state_next;
    logic        owner_d;     // 1: data owns the in-flight transaction
    logic        lat_we;
    logic        lat_err;
    logic [2:0]  starve_cnt;
    logic [63:0] pc_q;
    logic [31:0] rw_addr_q;
    logic [63:0] rw_val_q;
    logic [31:0] if_rdata_q;
    logic [63:0] d_rdata_q;
    logic        fetch_wins;

    // Arbitration and next state. Grants exist only in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves a value unassigned and no latch is inferred.
        state_next = state;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_TOP));
        case (state)
            IDLE: begin
                if_gnt = fetch_wins;
                d_gnt  = d_req && !fetch_wins;
                if (if_gnt || d_gnt) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the response-data registers are reset too: after reset
            // both rdata outputs must read 0 until a new response arrives.
            state      <= IDLE;
            owner_d    <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            starve_cnt <= '0;
            pc_q       <= '0;
            rw_addr_q  <= '0;
            rw_val_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_next;

            // The memory-port registers double as the latched request, so the
            // port shows the new address during ACCESS and holds afterwards.
            if (if_gnt) begin
                owner_d    <= 1'b0;
                pc_q       <= if_addr;
                lat_we     <= 1'b0;
                lat_err    <= (if_addr > IF_LIMIT);
                starve_cnt <= '0;
            end else if (d_gnt) begin
                owner_d   <= 1'b1;
                rw_addr_q <= d_addr;
                rw_val_q  <= d_wdata;
                lat_we    <= d_we;
                lat_err   <= (d_addr > D_LIMIT);
                if (if_req && (starve_cnt != STARVE_TOP)) begin
                    starve_cnt <= starve_cnt + 3'd1;
                end
            end

            // Capture read data on the edge leaving ACCESS (same edge a store
            // commits). Errors and stores return 0.
            if (state == ACCESS) begin
                if (owner_d) begin
                    d_rdata_q <= (lat_err || lat_we) ? '0 : mem_r_out;
                end else begin
                    if_rdata_q <= lat_err ? '0 : mem_instruction;
                end
            end
        end
    end

    // Decoded from registered state only, so the write enable falls the moment
    // reset asserts and can never glitch from the request inputs.
    assign mem_write_enable = (state == ACCESS) && lat_we && !lat_err;
    assign mem_pc           = pc_q;
    assign mem_rw_addr      = rw_addr_q;
    assign mem_rw_val       = rw_val_q;

    assign if_rvalid = (state == RESP) && !owner_d;
    assign d_rvalid  = (state == RESP) && owner_d;
    assign if_err    = if_rvalid && lat_err;
    assign d_err     = d_rvalid && lat_err;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter against a byte-array memory. A transaction-level model
// (in-flight countdown, starvation count, shadow memory) predicts grants,
// write enables, responses and held read data every cycle; directed
// sequences pin the model with hand-computed literals, then a randomized
// phase exercises contention, withdrawals and range boundaries.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MEM_BYTES  = 524288;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        d_err;
    logic [63:0] mem_pc;
    logic [31:0] mem_rw_addr;
    logic [63:0] mem_rw_val;
    logic        mem_write_enable;
    logic [31:0] mem_instruction;
    logic [63:0] mem_r_out;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;

    mem_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_pc(mem_pc), .mem_rw_addr(mem_rw_addr), .mem_rw_val(mem_rw_val),
        .mem_write_enable(mem_write_enable),
        .mem_instruction(mem_instruction), .mem_r_out(mem_r_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- memory harness (what the DUT actually talks to) -------
    logic [7:0] hmem [0:MEM_BYTES-1];
    // ---------------- shadow memory (what the model believes) ---------------
    logic [7:0] smem [0:MEM_BYTES-1];

    always_comb begin
        mem_instruction = '0;
        mem_r_out       = '0;
        for (int k = 0; k < 4; k++)
            mem_instruction[8*k +: 8] = hmem[19'(mem_pc[18:0] + 19'(k))];
        for (int k = 0; k < 8; k++)
            mem_r_out[8*k +: 8] = hmem[19'(mem_rw_addr[18:0] + 19'(k))];
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            we_cnt++;
            for (int k = 0; k < 8; k++)
                hmem[19'(mem_rw_addr[18:0] + 19'(k))] <= mem_rw_val[8*k +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] shadow_rd(input logic [63:0] a, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = smem[int'(a) + i];
        return r;
    endfunction

    // ---------------- transaction-level model + per-cycle compare -----------
    int          m_left;      // cycles until the in-flight transaction retires
    int          m_starve;
    bit          p_fetch, p_we, p_err;
    logic [63:0] p_addr, p_wdata;
    logic [31:0] m_if_rdata;
    logic [63:0] m_d_rdata;
    bit          e_fetch, e_data;

    always @(negedge clk) begin
        if (!reset) begin
            m_left = 0; m_starve = 0; m_if_rdata = '0; m_d_rdata = '0;
            check("rst_if_gnt", if_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_busy", busy, 0);
            check("rst_we", mem_write_enable, 0);
            check("rst_rvalid", {if_rvalid, d_rvalid, if_err, d_err}, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            check("rst_mem_port", {mem_pc, mem_rw_addr, mem_rw_val}, 0);
        end else begin
            e_fetch = 0;
            e_data  = 0;
            if (m_left == 0) begin
                if (if_req && (!d_req || m_starve == STARVE_MAX)) e_fetch = 1;
                else if (d_req) e_data = 1;
            end
            check("if_gnt", if_gnt, e_fetch);
            check("d_gnt", d_gnt, e_data);
            check("busy", busy, m_left != 0);
            check("mem_we", mem_write_enable, (m_left == 2) && p_we && !p_err);
            if (m_left == 2) begin
                if (p_fetch) check("mem_pc", mem_pc, p_addr);
                else check("mem_rw_addr", mem_rw_addr, p_addr[31:0]);
                if (!p_fetch && p_we) check("mem_rw_val", mem_rw_val, p_wdata);
            end
            check("if_rvalid", if_rvalid, (m_left == 1) && p_fetch);
            check("d_rvalid", d_rvalid, (m_left == 1) && !p_fetch);
            if (m_left == 1 && p_fetch) check("if_err", if_err, p_err);
            if (m_left == 1 && !p_fetch) check("d_err", d_err, p_err);
            check("if_rdata", if_rdata, m_if_rdata);
            check("d_rdata", d_rdata, m_d_rdata);

            // Advance to the upcoming edge.
            if (m_left == 2) begin
                if (p_fetch) begin
                    m_if_rdata = p_err ? '0 : shadow_rd(p_addr, 4)[31:0];
                end else if (p_we) begin
                    if (!p_err)
                        for (int i = 0; i < 8; i++) smem[int'(p_addr) + i] = p_wdata[8*i +: 8];
                    m_d_rdata = '0;
                end else begin
                    m_d_rdata = p_err ? '0 : shadow_rd(p_addr, 8);
                end
            end
            if (m_left != 0) begin
                m_left--;
            end else if (e_fetch) begin
                p_fetch = 1; p_we = 0; p_addr = if_addr; p_wdata = '0;
                p_err = (if_addr > 64'(MEM_BYTES - 4));
                m_starve = 0; m_left = 2;
            end else if (e_data) begin
                p_fetch = 0; p_we = d_we; p_addr = 64'(d_addr); p_wdata = d_wdata;
                p_err = (d_addr > 32'(MEM_BYTES - 8));
                if (if_req && m_starve < STARVE_MAX) m_starve++;
                m_left = 2;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic xact(input bit f, input bit we, input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat);
        bit got;
        lat = -1; rd = '0; er = 1'b0; got = 0;
        if (f) begin if_req = 1; if_addr = a; end
        else begin d_req = 1; d_we = we; d_addr = a[31:0]; d_wdata = wd; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = f ? if_gnt : d_gnt;
            if (!got) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        if (f) if_req = 0; else d_req = 0;
        if (!got) begin
            check(f ? "fetch_gnt_timeout" : "data_gnt_timeout", 0, 1);
            return;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (f ? if_rvalid : d_rvalid) begin
                lat = k;
                rd  = f ? 64'(if_rdata) : d_rdata;
                er  = f ? if_err : d_err;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rand_faddr();
        case ($urandom_range(0, 9))
            0:       return 64'(MEM_BYTES - 5 + int'($urandom_range(0, 4)));
            1:       return {$urandom, $urandom};
            default: return 64'h4000 + 64'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [31:0] rand_daddr();
        case ($urandom_range(0, 9))
            0:       return 32'(MEM_BYTES - 9 + int'($urandom_range(0, 8)));
            1:       return $urandom;
            default: return 32'h4000 + 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] rd, order, orig, now_v;
        logic        er;
        int          lat, w0, n;
        bit          got, seen, gi, gd;

        for (int i = 0; i < MEM_BYTES; i++) begin
            hmem[i] = 8'((i * 37 + 11) & 255);
            smem[i] = hmem[i];
        end
        hmem[32'h100] = 8'h13; hmem[32'h101] = 8'h05; hmem[32'h102] = 8'h10; hmem[32'h103] = 8'h00;
        for (int k = 0; k < 8; k++)
            hmem[MEM_BYTES - 8 + k] = (k < 4) ? 8'(k + 1) : 8'(8'hAA + 8'((k - 4) * 17));
        for (int i = 0; i < 4; i++) smem[32'h100 + i] = hmem[32'h100 + i];
        for (int k = 0; k < 8; k++) smem[MEM_BYTES - 8 + k] = hmem[MEM_BYTES - 8 + k];

        reset = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_we", mem_write_enable, 0);
        check("reset_rdata", {if_rdata, d_rdata}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;

        // Fetch alone.
        xact(1, 0, 64'h100, 0, rd, er, lat);
        check("fetch_lat", lat, 2);
        check("fetch_rdata", rd, 64'h00100513);
        check("fetch_err", er, 0);

        // Store then load.
        w0 = we_cnt;
        xact(0, 1, 64'h2000, 64'h1122334455667788, rd, er, lat);
        check("store_we_cycles", we_cnt - w0, 1);
        check("store_rdata", rd, 0);
        check("store_lat", lat, 2);
        xact(0, 0, 64'h2000, 0, rd, er, lat);
        check("load_rdata", rd, 64'h1122334455667788);
        check("load_err", er, 0);

        // Contention: grant order D,D,D,D,F,D,D,D,D,F,D,D,D,D (bit set = fetch).
        if_req = 1; if_addr = 64'h200; d_req = 1; d_we = 0; d_addr = 32'h2000;
        order = '0; n = 0;
        for (int c = 0; c < 80 && n < 14; c++) begin
            @(negedge clk);
            if (if_gnt) begin order[n] = 1'b1; n++; end
            else if (d_gnt) n++;
            @(posedge clk); #1;
        end
        check("grant_count", n, 14);
        check("grant_order", order, 64'h210);

        // Withdrawal: starve count is at max, so a data pulse loses to fetch.
        d_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_req = 1;
        @(negedge clk);
        check("withdraw_if_gnt", if_gnt, 1);
        check("withdraw_d_gnt", d_gnt, 0);
        @(posedge clk); #1;
        d_req = 0; if_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if_req = 1; d_req = 1;
        @(negedge clk);
        check("starve_cleared_d_gnt", d_gnt, 1);
        @(posedge clk); #1;
        if_req = 0; d_req = 0;
        repeat (3) begin @(posedge clk); #1; end

        // Range boundaries.
        w0 = we_cnt;
        xact(0, 0, 64'(MEM_BYTES - 7), 0, rd, er, lat);
        check("oor_load_err", er, 1);
        check("oor_load_rdata", rd, 0);
        check("oor_load_lat", lat, 2);
        xact(0, 1, 64'(MEM_BYTES - 4), 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat);
        check("oor_store_err", er, 1);
        check("oor_no_write", we_cnt - w0, 0);
        xact(1, 0, 64'(MEM_BYTES - 4), 0, rd, er, lat);
        check("edge_fetch_err", er, 0);
        check("edge_fetch_rdata", rd, 64'hDDCCBBAA);
        xact(1, 0, 64'(MEM_BYTES - 3), 0, rd, er, lat);
        check("oor_fetch_err", er, 1);
        check("oor_fetch_rdata", rd, 0);
        xact(0, 0, 64'(MEM_BYTES - 8), 0, rd, er, lat);
        check("edge_load_err", er, 0);
        check("edge_load_rdata", rd, 64'hDDCCBBAA04030201);
        xact(1, 0, {32'h1, 32'h100}, 0, rd, er, lat);
        check("wide_fetch_err", er, 1);

        // Reset during the ACCESS cycle of a store.
        for (int k = 0; k < 8; k++) orig[8*k +: 8] = hmem[32'h3000 + k];
        d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 64'hDEADBEEFCAFEF00D;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = d_gnt;
            if (!got) begin @(posedge clk); #1; end
        end
        check("rst_store_gnt", got, 1);
        @(posedge clk); #1;
        check("rst_store_we_before", mem_write_enable, 1);
        w0 = we_cnt;
        reset = 0; d_req = 0;
        #1;
        check("rst_store_we_drop", mem_write_enable, 0);
        check("rst_store_busy", busy, 0);
        seen = 0;
        repeat (2) begin @(negedge clk); seen |= d_rvalid; end
        @(posedge clk); #1 reset = 1;
        repeat (4) begin @(negedge clk); seen |= d_rvalid; end
        check("rst_store_no_rvalid", seen, 0);
        check("rst_store_no_we", we_cnt - w0, 0);
        for (int k = 0; k < 8; k++) now_v[8*k +: 8] = hmem[32'h3000 + k];
        check("rst_store_mem_unchanged", now_v, orig);
        @(posedge clk); #1;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gi = if_gnt; gd = d_gnt;
            @(posedge clk); #1;
            if (if_req) begin
                if (gi || $urandom_range(0, 15) == 0) if_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = rand_faddr();
            end
            if (d_req) begin
                if (gd || $urandom_range(0, 15) == 0) d_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = rand_daddr(); d_wdata = {$urandom, $urandom};
            end
        end
        if_req = 0; d_req = 0;
        repeat (4) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
